usb_tx_ctrl: RTL and testbench
==============================

Name: usb_tx_ctrl

Overview:
Transmit-side controller for the USB full-speed link. It accepts packet bytes over a valid/ready byte handshake and prepends the SYNC byte. It serialises LSB-first with bit stuffing and NRZI encoding, then terminates each packet with EOP. It drives d_plus/d_minus directly, so it is the peer of the receiver-side RCU on the same bus.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_start  input  1  one-cycle request to begin a packet; ignored unless idle
tx_data  input  8  next packet byte
tx_data_valid  input  1  tx_data holds a valid byte
tx_last  input  1  the byte on tx_data is the final byte of the packet
tx_ready  output  1  one-cycle pulse: tx_data/tx_last latched this cycle
d_plus  output  1  bus D+ line
d_minus  output  1  bus D- line
tx_busy  output  1  high from the cycle after tx_start until the return to IDLE
tx_done  output  1  one-cycle pulse on the first IDLE cycle after EOP
tx_error  output  1  one-cycle pulse when an underrun aborts the packet

Behaviour:
- Reset (async, any time, including mid-packet):
  - state=IDLE; d_plus=1, d_minus=0 (J).
  - tx_ready, tx_busy, tx_done, tx_error = 0; bit timer, ones counter and shift register cleared.
- States: IDLE, SYNC, LOAD, DATA, STUFF, EOP_SE0, EOP_J.
- Bit timer:
  - Free-runs modulo CLKS_PER_BIT while not IDLE; cleared on tx_start.
  - bit_end asserts on count CLKS_PER_BIT-1.
  - Each line value is held exactly CLKS_PER_BIT cycles.
- IDLE:
  - Line stays at J.
  - On tx_start, the next cycle enters SYNC with the shift register = 8'h80 and bit index 0.
  - The first SYNC bit is on the line from cycle 1 (tx_start at cycle 0).
- NRZI encoding:
  - Data bit 0 toggles (d_plus, d_minus) between J (1,0) and K (0,1).
  - Data bit 1 holds the current level.
  - Encoding applies to SYNC, data and stuffed bits.
  - SYNC therefore produces K J K J K J K K.
- Ones counter:
  - Incremented on each transmitted 1; cleared on each transmitted 0, including stuffed 0s.
  - Continuous across the SYNC/data boundary, so it equals 1 after SYNC.
- STUFF:
  - Entered after a bit_end that brings the ones count to 6.
  - Transmits one 0 (a toggle) for one bit period and consumes no data bit; then resumes.
  - A stuff due after the final data bit is still sent, before EOP.
- LOAD:
  - Occurs at the bit_end closing bit 7 of SYNC or of a data byte (after any pending STUFF).
  - If tx_data_valid=1: tx_ready pulses, tx_data/tx_last are latched, and DATA begins on the next cycle.
  - LOAD is zero-length; there are no gaps between bit periods.
- DATA:
  - 8 bits are sent LSB first.
  - At the bit_end of bit 7, if the latched last=1, go to EOP_SE0 (after any stuff); otherwise go to LOAD.
- Underrun: tx_data_valid=0 at a LOAD (not last) → tx_error pulses, the data byte is not sent, and the block goes to EOP_SE0.
- EOP_SE0: d_plus=d_minus=0 for 2 bit periods.
- EOP_J: J for 1 bit period, then IDLE; tx_done pulses on the first IDLE cycle.
- NRZI level and the ones counter reset to J/0 at each new packet.
- tx_start while tx_busy=1 is ignored, including in the tx_done cycle: the start is accepted only when state=IDLE.
- Back-to-back packets: tx_start may be asserted in the tx_done cycle.

Decomposition:
- Package usb_tx_pkg:
  - tx_state_t enum (4-bit).
  - SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2, LINE_J=2'b10, LINE_K=2'b01, LINE_SE0=2'b00.
- One sub-module: usb_bit_timer (CLKS_PER_BIT counter with clear/enable, emits bit_end).
- FSM, stuffing and NRZI stay in usb_tx_ctrl.

Test Plan:
- Reset mid-SYNC at cycle 20 → d_plus=1, d_minus=0, tx_busy=0 in the same cycle; a later tx_start gives a clean SYNC.
- tx_start, tx_data=8'h00 with tx_last=1 held valid → tx_ready at cycle 64.
  - Line: KJKJKJKK, then 8 toggles JKJKJKJK, SE0 for 16 cycles, J for 8 cycles.
  - tx_done at cycle 161-8*1=153 (19 bit times).
- tx_data=8'hFF with tx_last=1 → stuffed toggle after data bit 4 (6 ones, counting SYNC's final 1); 9 data bit periods; tx_done at cycle 161.
- Two bytes 8'h3F, 8'h01 (last) → stuff after bit 4 of 8'h3F; the 0s of 8'h3F clear the count; no stuff in 8'h01; tx_ready pulses at cycles 64 and 136.
- Underrun: first byte 8'hA5 valid, then tx_data_valid=0 at the second LOAD → tx_error pulse, SE0 immediately after 8'hA5's last bit, tx_done follows EOP.
- tx_start asserted while busy and again in the tx_done cycle → first ignored, second starts a new SYNC the next cycle.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_tx_pkg;

    // LOAD is a decision taken inside the closing bit_end cycle; the state
    // register never holds it, so bit periods follow each other without gaps.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SYNC    = 4'd1,
        LOAD    = 4'd2,
        DATA    = 4'd3,
        STUFF   = 4'd4,
        EOP_SE0 = 4'd5,
        EOP_J   = 4'd6
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         STUFF_LIMIT  = 6;
    localparam int         EOP_SE0_BITS = 2;

    // Line encodings as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // NRZI: a 1 holds the current level, a 0 swaps J and K.
    function automatic logic [1:0] nrzi_next(input logic [1:0] level, input logic bit_val);
        if (bit_val) begin
            return level;
        end
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last clock of each bit.
// Latency: bit_end is combinational from the count; clr takes effect next cycle.
// Backpressure: none; free-runs whenever enabled.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Modulo-CLKS_PER_BIT counter; a clear restarts the first bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB FS transmitter: SYNC prepend, LSB-first serialiser with bit stuffing, NRZI, EOP.
// Latency: first SYNC bit on the line the cycle after tx_start; each bit held CLKS_PER_BIT clocks.
// Backpressure: byte pulled (tx_ready) only at a byte boundary; no valid byte there aborts with tx_error.
module usb_tx_ctrl
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    tx_state_t  state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;   // bit within byte, or SE0 bit count in EOP
    logic [2:0] ones, ones_nxt;         // consecutive transmitted ones
    logic       last_q, last_nxt;       // current byte closes the packet
    logic       pend_q, pend_nxt;       // the stuffed bit in flight also closes a byte
    logic [1:0] line, line_nxt;         // {d_plus, d_minus}
    logic       done_q, done_nxt;

    logic       start_acc;
    logic       bit_end;
    logic       cur_bit;
    logic [2:0] ones_upd;
    logic       byte_end;

    assign start_acc = tx_start && (state == IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc),
        .en     (state != IDLE),
        .bit_end(bit_end)
    );

    // State and datapath registers; reset parks the bus at J.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            ones    <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            line    <= LINE_J;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
            ones    <= ones_nxt;
            last_q  <= last_nxt;
            pend_q  <= pend_nxt;
            line    <= line_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state, serialiser, stuffing and byte-boundary load decision.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        ones_nxt    = ones;
        last_nxt    = last_q;
        pend_nxt    = pend_q;
        line_nxt    = line;
        done_nxt    = 1'b0;
        tx_ready    = 1'b0;
        tx_error    = 1'b0;
        byte_end    = 1'b0;
        cur_bit     = (state == STUFF) ? 1'b0 : shreg[0];
        ones_upd    = cur_bit ? ones + 3'd1 : 3'd0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_nxt   = SYNC;
                    shreg_nxt   = SYNC_BYTE;
                    bit_idx_nxt = 3'd0;
                    ones_nxt    = 3'd0;
                    last_nxt    = 1'b0;
                    pend_nxt    = 1'b0;
                    line_nxt    = nrzi_next(LINE_J, SYNC_BYTE[0]);
                end
            end
            SYNC, DATA: begin
                if (bit_end) begin
                    ones_nxt    = ones_upd;
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (ones_upd == 3'(STUFF_LIMIT)) begin
                        state_nxt = STUFF;
                        pend_nxt  = (bit_idx == 3'd7);
                        line_nxt  = nrzi_next(line, 1'b0);
                    end else if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        line_nxt = nrzi_next(line, shreg[1]);
                    end
                end
            end
            STUFF: begin
                if (bit_end) begin
                    ones_nxt = 3'd0;
                    if (pend_q) begin
                        byte_end = 1'b1;
                    end else begin
                        // SYNC can never reach six ones, so a mid-byte stuff is always in DATA
                        state_nxt = DATA;
                        line_nxt  = nrzi_next(line, shreg[0]);
                    end
                end
            end
            EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx == 3'(EOP_SE0_BITS - 1)) begin
                        state_nxt = EOP_J;
                        line_nxt  = LINE_J;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                line_nxt  = LINE_J;
            end
        endcase

        // Byte boundary (the LOAD point): close the packet, pull the next byte, or abort.
        if (byte_end) begin
            if (last_q) begin
                state_nxt   = EOP_SE0;
                bit_idx_nxt = 3'd0;
                line_nxt    = LINE_SE0;
            end else if (tx_data_valid) begin
                tx_ready    = 1'b1;
                state_nxt   = DATA;
                shreg_nxt   = tx_data;
                last_nxt    = tx_last;
                bit_idx_nxt = 3'd0;
                pend_nxt    = 1'b0;
                line_nxt    = nrzi_next(line, tx_data[0]);
            end else begin
                tx_error    = 1'b1;
                state_nxt   = EOP_SE0;
                bit_idx_nxt = 3'd0;
                line_nxt    = LINE_SE0;
            end
        end
    end

    assign d_plus  = line[1];
    assign d_minus = line[0];
    assign tx_busy = (state != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Self-checking bench for usb_tx_ctrl against a bit-period reference model.
// Latency: n/a.
// Backpressure: bench supplies bytes on tx_ready, withholds them to force underruns.
module tb_usb_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    usb_tx_ctrl #(.CLKS_PER_BIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    // Packet under test
    logic [7:0] pkt_data [16];
    int         pkt_n;
    int         pkt_nvalid;

    // Reference model output: one line symbol per bit period, event cycles
    logic [1:0] exp_sym [$];
    int         exp_rdy [$];
    int         exp_err;
    int         exp_done;
    logic [1:0] m_lvl;
    int         m_ones;

    // Observed event cycles
    int obs_rdy [$];
    int obs_err;
    int obs_done;

    // One transmitted bit on the line, followed by a stuffed 0 after six ones.
    task automatic model_bit(input logic b);
        if (!b) m_lvl = ~m_lvl;
        exp_sym.push_back(m_lvl);
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
            m_lvl = ~m_lvl;
            exp_sym.push_back(m_lvl);
            m_ones = 0;
        end
    endtask

    // Build the full expected bus waveform of one packet in bit periods.
    task automatic build_model();
        logic [7:0] sync_b;
        logic [7:0] byt;
        exp_sym.delete();
        exp_rdy.delete();
        exp_err = -1;
        m_lvl   = 2'b10;
        m_ones  = 0;
        sync_b  = 8'h80;
        for (int i = 0; i < 8; i++) model_bit(sync_b[i]);
        for (int k = 0; k < pkt_n; k++) begin
            if (k >= pkt_nvalid) begin
                exp_err = 8 * exp_sym.size();
                break;
            end
            exp_rdy.push_back(8 * exp_sym.size());
            byt = pkt_data[k];
            for (int i = 0; i < 8; i++) model_bit(byt[i]);
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
        exp_done = 1 + 8 * exp_sym.size();
    endtask

    task automatic drive(input int idx);
        tx_data_valid = (idx < pkt_nvalid) && (idx < pkt_n);
        tx_last       = (idx == pkt_n - 1);
        tx_data       = (idx < 16) ? pkt_data[idx] : 8'h00;
    endtask

    // Send one packet and compare the bus and status pins every cycle.
    // Cycle 0 is the cycle tx_start is accepted in.
    task automatic run_packet(input string name, input int busy_cyc,
                              input bit chain_in, input bit chain_out);
        int         idx;
        bit         rdy_prev;
        bit         r;
        logic [1:0] el;
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        build_model();
        obs_rdy.delete();
        obs_err  = -1;
        obs_done = -1;
        idx      = 0;
        rdy_prev = 1'b0;
        if (!chain_in) begin
            @(posedge clk); #1;
            tx_start = 1'b1;
            drive(idx);
            @(negedge clk);
            obs_v = {d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy};
            n_cmp++;
            if (obs_v !== 6'b10_0000) begin
                n_bad++;
                $display("FAIL %s start cycle: {dp,dm,rdy,err,done,busy} got %b expected %b",
                         name, obs_v, 6'b10_0000);
            end
        end else begin
            drive(idx);
        end
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            @(posedge clk); #1;
            if (rdy_prev) idx++;
            tx_start = (cyc == busy_cyc) || (chain_out && cyc == exp_done);
            drive(idx);
            @(negedge clk);
            rdy_prev = tx_ready;
            r = 1'b0;
            foreach (exp_rdy[i]) if (exp_rdy[i] == cyc) r = 1'b1;
            el    = (cyc < exp_done) ? exp_sym[(cyc - 1) / 8] : 2'b10;
            exp_v = {el, r, cyc == exp_err, cyc == exp_done, cyc < exp_done};
            obs_v = {d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy};
            if (tx_ready) obs_rdy.push_back(cyc);
            if (tx_error) obs_err = cyc;
            if (tx_done && obs_done < 0) obs_done = cyc;
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s cycle %0d: {dp,dm,rdy,err,done,busy} got %b expected %b",
                         name, cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; tx_data_valid = 1'b0; tx_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy} !== 6'b10_0000) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b",
                     {d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy}, 6'b10_0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_zero();
        pkt_data[0] = 8'h00; pkt_n = 1; pkt_nvalid = 1;
        run_packet("zero_byte", -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_rdy.size() != 1 || obs_rdy[0] != 64) begin
            n_bad++;
            $display("FAIL zero_ready_cycle: got %0d pulses first at %0d, expected 1 at 64",
                     obs_rdy.size(), (obs_rdy.size() > 0) ? obs_rdy[0] : -1);
        end
        n_cmp++;
        if (obs_done != 153) begin
            n_bad++;
            $display("FAIL zero_done_cycle: got %0d expected 153", obs_done);
        end
    endtask

    task automatic test_stuff_ff();
        pkt_data[0] = 8'hFF; pkt_n = 1; pkt_nvalid = 1;
        run_packet("ff_stuff", -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done != 161) begin
            n_bad++;
            $display("FAIL ff_done_cycle: got %0d expected 161", obs_done);
        end
    endtask

    task automatic test_two_bytes();
        pkt_data[0] = 8'h3F; pkt_data[1] = 8'h01; pkt_n = 2; pkt_nvalid = 2;
        run_packet("two_bytes", -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_rdy.size() != 2 || obs_rdy[0] != 64 || obs_rdy[1] != 136) begin
            n_bad++;
            $display("FAIL two_ready_cycles: got %0d pulses (%0d,%0d) expected 2 at (64,136)",
                     obs_rdy.size(), (obs_rdy.size() > 0) ? obs_rdy[0] : -1,
                     (obs_rdy.size() > 1) ? obs_rdy[1] : -1);
        end
        n_cmp++;
        if (obs_done != 225) begin
            n_bad++;
            $display("FAIL two_done_cycle: got %0d expected 225", obs_done);
        end
    endtask

    task automatic test_underrun();
        pkt_data[0] = 8'hA5; pkt_data[1] = 8'h5A; pkt_n = 2; pkt_nvalid = 1;
        run_packet("underrun", -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_err != 128) begin
            n_bad++;
            $display("FAIL underrun_error_cycle: got %0d expected 128", obs_err);
        end
        n_cmp++;
        if (obs_done != 153) begin
            n_bad++;
            $display("FAIL underrun_done_cycle: got %0d expected 153", obs_done);
        end
    endtask

    task automatic test_back_to_back();
        pkt_data[0] = 8'h00; pkt_n = 1; pkt_nvalid = 1;
        run_packet("busy_start", 30, 1'b0, 1'b1);
        n_cmp++;
        if (obs_done != 153) begin
            n_bad++;
            $display("FAIL busy_start_done: got %0d expected 153", obs_done);
        end
        pkt_data[0] = 8'hFF; pkt_n = 1; pkt_nvalid = 1;
        run_packet("b2b_second", -1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_done != 161) begin
            n_bad++;
            $display("FAIL b2b_second_done: got %0d expected 161", obs_done);
        end
    endtask

    task automatic test_reset_mid();
        pkt_data[0] = 8'h00; pkt_n = 1; pkt_nvalid = 1;
        @(posedge clk); #1;
        tx_start = 1'b1;
        drive(0);
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            tx_start = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy} !== 6'b10_0000) begin
            n_bad++;
            $display("FAIL reset_mid_sync: got %b expected %b",
                     {d_plus, d_minus, tx_ready, tx_error, tx_done, tx_busy}, 6'b10_0000);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_packet("after_reset", -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done != 153) begin
            n_bad++;
            $display("FAIL after_reset_done: got %0d expected 153", obs_done);
        end
    endtask

    task automatic test_random();
        bit chain_prev = 1'b0;
        bit chain_next;
        for (int p = 0; p < 20; p++) begin
            pkt_n = $urandom_range(1, 4);
            for (int k = 0; k < pkt_n; k++)
                pkt_data[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            pkt_nvalid = ($urandom_range(0, 4) == 0) ? $urandom_range(0, pkt_n - 1) : pkt_n;
            chain_next = (p < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_packet($sformatf("random_%0d", p), -1, chain_prev, chain_next);
            chain_prev = chain_next;
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_stuff_ff();
        test_two_bytes();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
